// File: rtl/ipf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package ipf_pkg;

  localparam int unsigned IPF_WORD_BYTES = 4;

  typedef enum logic {S_RUN, S_HOLD} ipf_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
  } ipf_entry_t;

  function automatic logic [31:0] ipf_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ipf_fifo.sv
// Generic synchronous FIFO with clear; head is read straight from storage registers.
module ipf_fifo #(
  parameter int unsigned Depth = 4,
  parameter type T = logic [7:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  T                           wdata,
  input  logic                       pop,
  output T                           rdata,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Depth+1);

  T              mem [Depth];
  logic [AW-1:0] wptr, rptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (32'(count) == Depth);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (32'(p) == Depth - 1) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push && !rst && !clear) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher with redirect flush and in-flight discard.
// Define IPF_ASSERT_EN to compile in the protocol/occupancy assertions.
module instr_prefetch_buffer
  import ipf_pkg::*;
#(
  parameter int unsigned Depth          = 4,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [31:0] BootAddr       = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fetch_en_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        fetch_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int CW = $clog2(Depth+1);
  localparam int OW = $clog2(MaxOutstanding+1);

  ipf_state_e    state;
  logic [OW-1:0] outstanding, discard, out_nxt;
  logic [31:0]   issue_addr, resp_addr, hold_addr, load_addr;
  logic [CW-1:0] count;
  logic          req_ok, granted, pending, drop, push, pop, empty, load, to_hold;
  ipf_entry_t    push_entry, head;

  assign req_ok    = fetch_en_i && ((32'(count) + 32'(outstanding)) < Depth)
                     && (outstanding < OW'(MaxOutstanding));
  assign mem_req_o = !RST && (state == S_HOLD || req_ok);
  assign mem_addr_o = issue_addr;

  assign granted = mem_req_o && mem_gnt_i;
  assign pending = mem_req_o && !mem_gnt_i;
  assign out_nxt = outstanding + OW'(granted) - OW'(mem_rvalid_i);
  assign drop    = mem_rvalid_i && (discard != '0);
  assign push    = mem_rvalid_i && (discard == '0) && !branch_i && (state == S_RUN);

  // A redirect with an ungranted request parks in S_HOLD so the bus request stays stable.
  assign to_hold   = (state == S_RUN) && branch_i && pending;
  assign load      = ((state == S_RUN) && branch_i && !pending) || ((state == S_HOLD) && mem_gnt_i);
  assign load_addr = ipf_align((state == S_HOLD && !branch_i) ? hold_addr : branch_addr_i);

  assign push_entry = '{rdata: mem_rdata_i, err: mem_err_i, addr: resp_addr};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_RUN;
      outstanding <= '0;
      discard     <= '0;
      issue_addr  <= ipf_align(BootAddr);
      resp_addr   <= ipf_align(BootAddr);
      hold_addr   <= '0;
    end else begin
      outstanding <= out_nxt;
      // After a redirect every request still in flight is stale.
      if (branch_i || state == S_HOLD) discard <= out_nxt;
      else if (drop)                   discard <= discard - OW'(1);

      if (load) begin
        issue_addr <= load_addr;
        resp_addr  <= load_addr;
      end else begin
        if (granted) issue_addr <= issue_addr + IPF_WORD_BYTES;
        if (push)    resp_addr  <= resp_addr + IPF_WORD_BYTES;
      end

      case (state)
        S_RUN:  if (to_hold) begin
                  state     <= S_HOLD;
                  hold_addr <= ipf_align(branch_addr_i);
                end
        S_HOLD: if (mem_gnt_i)     state     <= S_RUN;
                else if (branch_i) hold_addr <= ipf_align(branch_addr_i);
        default: state <= S_RUN;
      endcase
    end
  end

  ipf_fifo #(.Depth(Depth), .T(ipf_entry_t)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .clear (branch_i),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .count (count)
  );

  assign fetch_valid_o = !empty;
  assign pop           = fetch_valid_o && fetch_ready_i;
  assign fetch_rdata_o = fetch_valid_o ? head.rdata : '0;
  assign fetch_addr_o  = fetch_valid_o ? head.addr  : '0;
  assign fetch_err_o   = fetch_valid_o && head.err;

`ifdef IPF_ASSERT_EN
  a_req_stable: assert property (@(posedge CLK) disable iff (RST)
    mem_req_o && !mem_gnt_i |=> mem_req_o && $stable(mem_addr_o));
  a_no_spurious_rvalid: assert property (@(posedge CLK) disable iff (RST)
    mem_rvalid_i |-> outstanding != '0);
  a_outstanding_max: assert property (@(posedge CLK) disable iff (RST)
    32'(outstanding) <= MaxOutstanding);
  a_count_max: assert property (@(posedge CLK) disable iff (RST)
    32'(count) <= Depth);
  a_addr_aligned: assert property (@(posedge CLK) disable iff (RST)
    mem_addr_o[1:0] == 2'b00);
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    push && 32'(count) == Depth |-> pop);
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench: vector table for streaming/backpressure, hand sequences for redirect, error, reset.
module tb_instr_prefetch_buffer;

  logic        CLK, RST;
  logic        fetch_en_i, branch_i, fetch_ready_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o, fetch_err_o, mem_req_o;
  logic [31:0] fetch_rdata_o, fetch_addr_o, mem_addr_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;

  logic        resp_hold;
  logic [31:0] err_addr;
  logic [31:0] q[$];
  int          n_chk = 0;
  int          n_err = 0;

  typedef struct {
    logic        en, rdy, gnt;
    logic        vld;
    logic [31:0] faddr;
    logic        req;
    logic [31:0] maddr;
  } vec_t;
  vec_t tbl[15];

  instr_prefetch_buffer dut (
    .CLK(CLK), .RST(RST), .fetch_en_i(fetch_en_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .fetch_valid_o(fetch_valid_o),
    .fetch_ready_i(fetch_ready_i), .fetch_rdata_o(fetch_rdata_o),
    .fetch_addr_o(fetch_addr_o), .fetch_err_o(fetch_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: responds one cycle after grant, in order, unless held off.
  initial begin
    mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
  end
  always @(posedge CLK) begin
    if (RST) q.delete();
    else begin
      if (mem_rvalid_i) void'(q.pop_front());
      if (mem_req_o && mem_gnt_i) q.push_back(mem_addr_o);
    end
    #2;
    if (RST || resp_hold || q.size() == 0) begin
      mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
    end else begin
      mem_rvalid_i = 1; mem_rdata_i = mw(q[0]); mem_err_i = (q[0] == err_addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic v, input logic [31:0] fa,
                         input logic [31:0] rd, input logic er, input logic rq,
                         input logic [31:0] ma);
    chk({nm, ".valid"}, 32'(fetch_valid_o), 32'(v));
    chk({nm, ".faddr"}, fetch_addr_o, fa);
    chk({nm, ".rdata"}, fetch_rdata_o, rd);
    chk({nm, ".err"},   32'(fetch_err_o), 32'(er));
    chk({nm, ".req"},   32'(mem_req_o), 32'(rq));
    chk({nm, ".maddr"}, mem_addr_o, ma);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1; fetch_en_i = 0; fetch_ready_i = 0; mem_gnt_i = 0;
    branch_i = 0; branch_addr_i = 0; resp_hold = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_all("reset", 0, 0, 0, 0, 0, 32'h0);
    cyc();
    RST = 0;
  endtask

  initial begin
    err_addr = 32'hFFFF_FFFF;
    //         en    rdy   gnt   vld   faddr   req   maddr
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00, 1'b1, 32'h08};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0C};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h10};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h14};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h18};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h1C};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h1C};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h1C};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h1C};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h20};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h24};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h28};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h2C};

    do_reset();
    // Streaming, then backpressure fill to Depth and drain.
    for (int i = 0; i < 15; i++) begin
      fetch_en_i = tbl[i].en; fetch_ready_i = tbl[i].rdy; mem_gnt_i = tbl[i].gnt;
      @(negedge CLK);
      chk_all($sformatf("vec%0d", i), tbl[i].vld, tbl[i].faddr,
              tbl[i].vld ? mw(tbl[i].faddr) : 32'h0, 1'b0, tbl[i].req, tbl[i].maddr);
      cyc();
    end

    // Redirect with two requests in flight; one response lands in the branch cycle.
    do_reset();
    fetch_en_i = 1; fetch_ready_i = 1; mem_gnt_i = 1; resp_hold = 1;
    cyc(); cyc();
    branch_i = 1; branch_addr_i = 32'h103; resp_hold = 0;
    @(negedge CLK); chk("br.req_at_max", 32'(mem_req_o), 0);
    cyc();
    branch_i = 0;
    @(negedge CLK); chk("br.stale1", 32'(fetch_valid_o), 0); chk("br.target", mem_addr_o, 32'h100);
    cyc();
    @(negedge CLK); chk("br.stale2", 32'(fetch_valid_o), 0); chk("br.next", mem_addr_o, 32'h104);
    cyc();
    @(negedge CLK); chk_all("br.head", 1, 32'h100, mw(32'h100), 0, 1, 32'h108);
    cyc();

    // Redirect while a request waits for grant.
    do_reset();
    fetch_en_i = 0; fetch_ready_i = 1; mem_gnt_i = 0; branch_i = 1; branch_addr_i = 32'h20;
    @(negedge CLK); chk("hold.idle_req", 32'(mem_req_o), 0);
    cyc();
    fetch_en_i = 1; branch_i = 0;
    @(negedge CLK); chk("hold.req0", 32'(mem_req_o), 1); chk("hold.addr0", mem_addr_o, 32'h20);
    cyc();
    branch_i = 1; branch_addr_i = 32'h203;
    @(negedge CLK); chk("hold.addr1", mem_addr_o, 32'h20);
    cyc();
    branch_i = 0;
    @(negedge CLK); chk("hold.req2", 32'(mem_req_o), 1); chk("hold.addr2", mem_addr_o, 32'h20);
    cyc();
    mem_gnt_i = 1;
    @(negedge CLK); chk("hold.addr3", mem_addr_o, 32'h20);
    cyc();
    @(negedge CLK); chk("hold.stale1", 32'(fetch_valid_o), 0); chk("hold.target", mem_addr_o, 32'h200);
    cyc();
    @(negedge CLK); chk("hold.stale2", 32'(fetch_valid_o), 0); chk("hold.next", mem_addr_o, 32'h204);
    cyc();
    @(negedge CLK); chk("hold.head", fetch_addr_o, 32'h200); chk("hold.rdata", fetch_rdata_o, mw(32'h200));
    cyc();

    // Bus error on the 0x8 word travels with that entry only.
    do_reset();
    err_addr = 32'h8;
    fetch_en_i = 1; fetch_ready_i = 0; mem_gnt_i = 1;
    repeat (6) cyc();
    fetch_en_i = 0; fetch_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk_all($sformatf("err%0d", i), 1, 32'(4*i), mw(32'(4*i)), (i == 2), 0, 32'h10);
      cyc();
    end
    @(negedge CLK); chk("err.drained", 32'(fetch_valid_o), 0);
    err_addr = 32'hFFFF_FFFF;

    // One-cycle reset with entries buffered and a request in flight.
    do_reset();
    fetch_en_i = 1; fetch_ready_i = 0; mem_gnt_i = 1;
    repeat (3) cyc();
    @(negedge CLK); chk("mrst.pre_valid", 32'(fetch_valid_o), 1); chk("mrst.pre_head", fetch_addr_o, 32'h0);
    cyc();
    RST = 1; fetch_en_i = 0;
    cyc();
    RST = 0;
    @(negedge CLK); chk_all("mrst.after", 0, 0, 0, 0, 0, 32'h0);
    cyc();
    fetch_en_i = 1;
    @(negedge CLK); chk_all("mrst.boot", 0, 0, 0, 0, 1, 32'h0);
    cyc();
    @(negedge CLK); chk("mrst.stale", 32'(fetch_valid_o), 0); chk("mrst.addr1", mem_addr_o, 32'h4);
    cyc();
    @(negedge CLK); chk("mrst.head", fetch_addr_o, 32'h0); chk("mrst.rdata", fetch_rdata_o, mw(32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
